// File: rtl/exe_stage_mc_if.sv
// ---------------------------------------------------------------------------
// exe_stage_mc_if
//   Bundles the execute stage's bus signals:
//     - decode -> ES instruction (ds_to_es_valid / es_allowin, in_* fields)
//     - ES -> MS instruction (es_to_ms_valid / ms_allowin, es_* fields)
//     - data SRAM request (data_sram_*)
//     - forwarding port back to decode (es_fwd_*)
//   modport slave  : the execute stage itself
//   modport master : the environment around it (decode, MS, SRAM)
// ---------------------------------------------------------------------------
interface exe_stage_mc_if #(
   parameter int XLEN = 32,
   parameter int NB   = XLEN / 8
);
   localparam int AW = $clog2(NB);

   // decode -> ES
   logic            ds_to_es_valid;
   logic            es_allowin;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_src1;
   logic [XLEN-1:0] in_src2;
   logic [XLEN-1:0] in_st_data;
   logic [11:0]     in_alu_op;
   logic            in_div_en;
   logic [1:0]      in_div_op;
   logic            in_load;
   logic            in_store;
   logic [1:0]      in_mem_size;
   logic            in_gr_we;
   logic [4:0]      in_dest;

   // ES -> MS
   logic            ms_allowin;
   logic            es_to_ms_valid;
   logic [XLEN-1:0] es_pc;
   logic [XLEN-1:0] es_result;
   logic            es_load;
   logic            es_gr_we;
   logic            es_ale;
   logic [4:0]      es_dest;
   logic [1:0]      es_mem_size;
   logic [AW-1:0]   es_addr_lo;

   // data SRAM request
   logic            data_sram_en;
   logic [NB-1:0]   data_sram_we;
   logic [XLEN-1:0] data_sram_addr;
   logic [XLEN-1:0] data_sram_wdata;

   // forwarding back to decode
   logic            es_fwd_valid;
   logic            es_fwd_block;
   logic [4:0]      es_fwd_dest;
   logic [XLEN-1:0] es_fwd_data;

   modport slave (
      input  ds_to_es_valid, in_pc, in_src1, in_src2, in_st_data, in_alu_op,
             in_div_en, in_div_op, in_load, in_store, in_mem_size, in_gr_we,
             in_dest, ms_allowin,
      output es_allowin, es_to_ms_valid, es_pc, es_result, es_load, es_gr_we,
             es_ale, es_dest, es_mem_size, es_addr_lo, data_sram_en,
             data_sram_we, data_sram_addr, data_sram_wdata, es_fwd_valid,
             es_fwd_block, es_fwd_dest, es_fwd_data
   );

   modport master (
      output ds_to_es_valid, in_pc, in_src1, in_src2, in_st_data, in_alu_op,
             in_div_en, in_div_op, in_load, in_store, in_mem_size, in_gr_we,
             in_dest, ms_allowin,
      input  es_allowin, es_to_ms_valid, es_pc, es_result, es_load, es_gr_we,
             es_ale, es_dest, es_mem_size, es_addr_lo, data_sram_en,
             data_sram_we, data_sram_addr, data_sram_wdata, es_fwd_valid,
             es_fwd_block, es_fwd_dest, es_fwd_data
   );
endinterface

// File: rtl/exe_stage_mc.sv
// ---------------------------------------------------------------------------
// exe_stage_mc
//   Execute stage of the in-order pipeline with an iterative restoring
//   divider (stalls the stage), sub-word store lane generation with
//   alignment checking, a forwarding port to decode and a flush input.
//   Ports:
//     clk, reset     clock; synchronous active-high reset
//     flush          kills the instruction in ES and aborts the divider
//     bus            exe_stage_mc_if.slave (decode, MS, SRAM, forwarding)
//     dbg_div_state  current divider FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   XLEN must be 32 or 64. Divides are 32-bit ops on the low operand bits,
//   result sign-extended to XLEN.
// ---------------------------------------------------------------------------
module exe_stage_mc #(
   parameter int XLEN = 32,
   parameter int NB   = XLEN / 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   exe_stage_mc_if.slave  bus,
   output logic [1:0]     dbg_div_state
);
   localparam int AW = $clog2(NB);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      logic [XLEN-1:0] st_data;
      logic [11:0]     alu_op;
      logic            div_en;
      logic [1:0]      div_op;
      logic            load;
      logic            store;
      logic [1:0]      mem_size;
      logic            gr_we;
      logic [4:0]      dest;
   } es_fields_t;

   // Handshake: a stage holds its instruction while valid; it may take a new
   // one when allowin is high. A transfer happens on the edge where the
   // producer's valid and the consumer's allowin are both high. allowin
   // never depends on the incoming valid.

   logic          es_valid_q, es_valid_d;
   es_fields_t    f_q, f_d;
   div_state_e    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;

   logic es_ready_go, es_allowin, es_to_ms_valid;

   // ---------------- ALU (one-hot op) ----------------
   logic [XLEN-1:0] alu_result;
   logic [SW-1:0]   shamt;
   always_comb begin
      shamt      = f_q.src2[SW-1:0];
      alu_result = '0;
      if (f_q.alu_op[0])  alu_result |= f_q.src1 + f_q.src2;
      if (f_q.alu_op[1])  alu_result |= f_q.src1 - f_q.src2;
      if (f_q.alu_op[2])  alu_result |= XLEN'($signed(f_q.src1) < $signed(f_q.src2));
      if (f_q.alu_op[3])  alu_result |= XLEN'(f_q.src1 < f_q.src2);
      if (f_q.alu_op[4])  alu_result |= f_q.src1 & f_q.src2;
      if (f_q.alu_op[5])  alu_result |= ~(f_q.src1 | f_q.src2);
      if (f_q.alu_op[6])  alu_result |= f_q.src1 | f_q.src2;
      if (f_q.alu_op[7])  alu_result |= f_q.src1 ^ f_q.src2;
      if (f_q.alu_op[8])  alu_result |= f_q.src1 << shamt;
      if (f_q.alu_op[9])  alu_result |= f_q.src1 >> shamt;
      if (f_q.alu_op[10]) alu_result |= XLEN'($signed(f_q.src1) >>> shamt);
      if (f_q.alu_op[11]) alu_result |= f_q.src2;
   end

   // ---------------- divider datapath ----------------
   // Operand magnitudes and signs are derived from the held operands, which
   // stay stable while the divide occupies ES.
   logic [31:0]     a32, b32, a_abs, b_abs, q_fix, r_fix, res32;
   logic            is_signed, a_neg, b_neg, div_zero;
   logic [XLEN:0]   shifted, trial;
   logic [XLEN-1:0] div_result;
   always_comb begin
      a32       = f_q.src1[31:0];
      b32       = f_q.src2[31:0];
      is_signed = ~f_q.div_op[1];
      a_neg     = is_signed & a32[31];
      b_neg     = is_signed & b32[31];
      a_abs     = a_neg ? (~a32 + 32'd1) : a32;
      b_abs     = b_neg ? (~b32 + 32'd1) : b32;
      div_zero  = (b32 == 32'd0);
      // Restoring step: bring in the next dividend bit, try subtracting.
      shifted   = {rem_q, quo_q[XLEN-1]};
      trial     = shifted - {1'b0, XLEN'(b_abs)};
      q_fix     = (a_neg ^ b_neg) ? (~quo_q[31:0] + 32'd1) : quo_q[31:0];
      r_fix     = a_neg ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
      if (div_zero) begin
         q_fix = 32'hFFFF_FFFF;
         r_fix = a32;
      end
      res32      = f_q.div_op[0] ? r_fix : q_fix;
      div_result = XLEN'($signed(res32));
   end

   // ---------------- pipeline control ----------------
   always_comb begin
      es_ready_go    = ~f_q.div_en | (state_q == DIV_DONE);
      es_allowin     = ~es_valid_q | (es_ready_go & bus.ms_allowin);
      es_to_ms_valid = es_valid_q & es_ready_go & ~flush;
   end

   always_comb begin
      es_valid_d = es_valid_q;
      f_d        = f_q;
      if (es_allowin) begin
         es_valid_d = bus.ds_to_es_valid;
         f_d = '{pc: bus.in_pc, src1: bus.in_src1, src2: bus.in_src2,
                 st_data: bus.in_st_data, alu_op: bus.in_alu_op,
                 div_en: bus.in_div_en, div_op: bus.in_div_op,
                 load: bus.in_load, store: bus.in_store,
                 mem_size: bus.in_mem_size, gr_we: bus.in_gr_we,
                 dest: bus.in_dest};
      end
      if (flush) es_valid_d = 1'b0;
   end

   // ---------------- divider FSM ----------------
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      case (state_q)
         DIV_IDLE: begin
            if (es_valid_q && f_q.div_en && !flush) begin
               rem_d   = '0;
               quo_d   = XLEN'(a_abs);
               count_d = CW'(XLEN);
               state_d = DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (es_to_ms_valid && bus.ms_allowin) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush) state_d = DIV_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_q <= 1'b0;
         f_q        <= '0;
         state_q    <= DIV_IDLE;
         count_q    <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
      end else begin
         es_valid_q <= es_valid_d;
         f_q        <= f_d;
         state_q    <= state_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
      end
   end

   // ---------------- memory request ----------------
   logic [XLEN-1:0] es_result;
   logic [AW-1:0]   addr_lo;
   logic            mem_op, misaligned, es_ale;
   logic [7:0]      lane_mask;
   logic [15:0]     we_wide;
   int              lane_lim;
   always_comb begin
      es_result = f_q.div_en ? div_result : alu_result;
      addr_lo   = alu_result[AW-1:0];
      mem_op    = es_valid_q & (f_q.load | f_q.store);
      case (f_q.mem_size)
         2'd0:    begin misaligned = 1'b0;               lane_mask = 8'h01; end
         2'd1:    begin misaligned = alu_result[0];      lane_mask = 8'h03; end
         2'd2:    begin misaligned = |alu_result[1:0];   lane_mask = 8'h0F; end
         default: begin misaligned = |alu_result[2:0];   lane_mask = 8'hFF; end
      endcase
      es_ale  = mem_op & misaligned;
      we_wide = {8'h00, lane_mask} << addr_lo;
      // Replicate the low (1<<size) bytes of the store data across all lanes.
      lane_lim = (1 << f_q.mem_size) - 1;
      for (int i = 0; i < NB; i++) begin
         bus.data_sram_wdata[8*i +: 8] = f_q.st_data[8*(i & lane_lim) +: 8];
      end
   end

   assign bus.es_allowin     = es_allowin;
   assign bus.es_to_ms_valid = es_to_ms_valid;
   assign bus.es_pc          = f_q.pc;
   assign bus.es_result      = es_result;
   assign bus.es_load        = f_q.load;
   assign bus.es_gr_we       = f_q.gr_we;
   assign bus.es_ale         = es_ale;
   assign bus.es_dest        = f_q.dest;
   assign bus.es_mem_size    = f_q.mem_size;
   assign bus.es_addr_lo     = addr_lo;
   // The request goes out only in the handoff cycle so it is issued once.
   assign bus.data_sram_en   = mem_op & ~es_ale & bus.ms_allowin & ~flush;
   assign bus.data_sram_we   = (es_valid_q & f_q.store) ? NB'(we_wide) : '0;
   assign bus.data_sram_addr = alu_result;
   assign bus.es_fwd_valid   = es_valid_q & f_q.gr_we;
   assign bus.es_fwd_block   = es_valid_q & (f_q.load | (f_q.div_en & (state_q != DIV_DONE)));
   assign bus.es_fwd_dest    = f_q.dest;
   assign bus.es_fwd_data    = es_result;
   assign dbg_div_state      = state_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
   localparam int XLEN = 32;
   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

   logic clk, reset, flush;
   logic [1:0] dbg;
   exe_stage_mc_if #(.XLEN(XLEN)) bus ();
   exe_stage_mc #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus), .dbg_div_state(dbg));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [XLEN-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic        h_en, h_ale, h_allowin, h_fwd_valid, h_blk_first;
   logic [3:0]  h_we;
   logic [31:0] h_wdata, h_addr, h_fwd_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      n_fail++;
      $error("FAIL %s: timed out waiting for DUT", tag);
   endtask

   // ---------------- reference models ----------------
   function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a; sb = b;
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (!op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
         return op[0] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[0] ? a % b : a / b;
   endfunction

   function automatic logic [31:0] alu_model(input int idx, input logic [31:0] a, input logic [31:0] b);
      case (idx)
         0: return a + b;
         1: return a - b;
         2: return {31'd0, $signed(a) < $signed(b)};
         3: return {31'd0, a < b};
         4: return a & b;
         5: return ~(a | b);
         6: return a | b;
         7: return a ^ b;
         8: return a << b[4:0];
         9: return a >> b[4:0];
         10: return 32'($signed(a) >>> b[4:0]);
         default: return b;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      bus.ds_to_es_valid = 0; bus.in_pc = 0; bus.in_src1 = 0; bus.in_src2 = 0;
      bus.in_st_data = 0; bus.in_alu_op = 0; bus.in_div_en = 0; bus.in_div_op = 0;
      bus.in_load = 0; bus.in_store = 0; bus.in_mem_size = 0; bus.in_gr_we = 0;
      bus.in_dest = 0;
   endtask

   task automatic issue(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] sd,
                        input logic [11:0] op, input logic div_en, input logic [1:0] div_op,
                        input logic ld, input logic st, input logic [1:0] sz, input logic [4:0] dest);
      bit ok;
      bus.in_pc = 32'h1c00_0000 + 32'($urandom_range(0, 255) * 4);
      bus.in_src1 = s1; bus.in_src2 = s2; bus.in_st_data = sd; bus.in_alu_op = op;
      bus.in_div_en = div_en; bus.in_div_op = div_op; bus.in_load = ld; bus.in_store = st;
      bus.in_mem_size = sz; bus.in_gr_we = ~st; bus.in_dest = dest;
      bus.ds_to_es_valid = 1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.es_allowin;
      end
      if (!ok) timeout_fail("issue");
      @(posedge clk); #1;
      clear_inputs();
   endtask

   // Waits for the handoff to MS, pops the scoreboard and captures side outputs.
   task automatic wait_handoff(input string tag, output int cyc);
      bit found;
      found = 0; cyc = 0;
      for (int i = 1; i <= 200 && !found; i++) begin
         @(negedge clk);
         if (i == 1) h_blk_first = bus.es_fwd_block;
         if (bus.es_to_ms_valid && bus.ms_allowin) begin
            found = 1; cyc = i;
            h_en = bus.data_sram_en; h_we = bus.data_sram_we; h_wdata = bus.data_sram_wdata;
            h_ale = bus.es_ale; h_addr = bus.data_sram_addr; h_allowin = bus.es_allowin;
            h_fwd_valid = bus.es_fwd_valid; h_fwd_data = bus.es_fwd_data;
            if (exp_q.size() == 0) timeout_fail({tag, "_empty_queue"});
            else check({tag, "_result"}, bus.es_result, exp_q.pop_front());
         end
      end
      if (!found) timeout_fail({tag, "_handoff"});
      @(posedge clk); #1;
   endtask

   task automatic wait_state(input logic [1:0] st, input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = (dbg == st);
      end
      if (!ok) timeout_fail(tag);
   endtask

   task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      exp_q.push_back(div_model(op, a, b));
      issue(a, b, 0, 12'h001, 1, op, 0, 0, 2'd2, 5'd4);
      wait_handoff(tag, cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'(XLEN + 2));
      check({tag, "_fwd_block"}, 32'(h_blk_first), 32'd1);
   endtask

   task automatic do_alu(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      exp_q.push_back(alu_model(idx, a, b));
      issue(a, b, 0, 12'(1) << idx, 0, 0, 0, 0, 2'd2, 5'd3);
      wait_handoff(tag, cyc);
      check({tag, "_cycles"}, 32'(cyc), 32'd1);
   endtask

   task automatic do_store(input string tag, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] sd, input logic [1:0] sz);
      int cyc;
      exp_q.push_back(base + off);
      issue(base, off, sd, 12'h001, 0, 0, 0, 1, sz, 5'd0);
      wait_handoff(tag, cyc);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc, en_cnt, hand_cnt;
      logic [31:0] ra, rb;
      clear_inputs();
      flush = 0; bus.ms_allowin = 1; reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_to_ms_valid", 32'(bus.es_to_ms_valid), 0);
      check("rst_sram_en", 32'(bus.data_sram_en), 0);
      check("rst_sram_we", 32'(bus.data_sram_we), 0);
      check("rst_fwd_valid", 32'(bus.es_fwd_valid), 0);
      check("rst_fwd_block", 32'(bus.es_fwd_block), 0);
      check("rst_ale", 32'(bus.es_ale), 0);
      check("rst_allowin", 32'(bus.es_allowin), 1);
      check("rst_state", 32'(dbg), 32'(S_IDLE));
      @(posedge clk); #1 reset = 0;

      // ADD 3+4
      exp_q.push_back(32'd7);
      issue(3, 4, 0, 12'h001, 0, 0, 0, 0, 2'd2, 5'd5);
      wait_handoff("add", cyc);
      check("add_cycles", 32'(cyc), 1);
      check("add_allowin", 32'(h_allowin), 1);
      check("add_fwd_valid", 32'(h_fwd_valid), 1);
      check("add_fwd_data", h_fwd_data, 7);

      // divider directed cases
      do_div("div_neg7_2", 2'b00, 32'hFFFF_FFF9, 2);
      do_div("mod_neg7_2", 2'b01, 32'hFFFF_FFF9, 2);
      do_div("div_5_0", 2'b00, 5, 0);
      do_div("modu_5_0", 2'b11, 5, 0);
      do_div("div_min_m1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("mod_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) begin
         ra = $urandom; rb = 32'($urandom_range(1, 1000));
         if (k[0]) rb = -rb;
         do_div("div_rand", 2'(k), ra, rb);
      end

      // random ALU ops
      for (int k = 0; k < 6; k++) do_alu("alu_rand", $urandom_range(0, 11), $urandom, $urandom);

      // stores
      do_store("stb", 32'h1000, 3, 32'h0000_00AB, 2'd0);
      check("stb_en", 32'(h_en), 1);
      check("stb_we", 32'(h_we), 32'b1000);
      check("stb_wdata", h_wdata, 32'hABAB_ABAB);
      check("stb_addr", h_addr, 32'h1003);
      do_store("sth_mis", 32'h1000, 1, 32'h0000_1234, 2'd1);
      check("sth_mis_ale", 32'(h_ale), 1);
      check("sth_mis_en", 32'(h_en), 0);
      do_store("sth", 32'h2000, 2, 32'h5555_BEEF, 2'd1);
      check("sth_we", 32'(h_we), 32'b1100);
      check("sth_wdata", h_wdata, 32'hBEEF_BEEF);
      do_store("stw", 32'h2000, 4, 32'h1234_5678, 2'd2);
      check("stw_we", 32'(h_we), 32'b1111);
      check("stw_wdata", h_wdata, 32'h1234_5678);

      // load with MS back-pressure for 3 cycles
      bus.ms_allowin = 0;
      exp_q.push_back(32'h3008);
      issue(32'h3000, 8, 0, 12'h001, 0, 0, 1, 0, 2'd2, 5'd6);
      en_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         en_cnt += int'(bus.data_sram_en);
         if (k == 0) begin
            check("ld_bp_allowin", 32'(bus.es_allowin), 0);
            check("ld_fwd_block", 32'(bus.es_fwd_block), 1);
         end
      end
      @(posedge clk); #1 bus.ms_allowin = 1;
      wait_handoff("ld_bp", cyc);
      en_cnt += int'(h_en);
      @(negedge clk);
      en_cnt += int'(bus.data_sram_en);
      check("ld_bp_en_pulses", 32'(en_cnt), 1);

      // divide held in DONE by back-pressure
      exp_q.push_back(32'd14);
      issue(100, 7, 0, 12'h001, 1, 2'b00, 0, 0, 2'd2, 5'd7);
      bus.ms_allowin = 0;
      wait_state(S_DONE, "bp_reach_done");
      hand_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("bp_hold_result", bus.es_result, 14);
         check("bp_hold_state", 32'(dbg), 32'(S_DONE));
         hand_cnt += int'(bus.es_to_ms_valid && bus.ms_allowin);
      end
      @(posedge clk); #1 bus.ms_allowin = 1;
      wait_handoff("bp_div", cyc);
      hand_cnt++;
      check("bp_div_cycles", 32'(cyc), 1);
      @(negedge clk);
      hand_cnt += int'(bus.es_to_ms_valid);
      check("bp_single_handoff", 32'(hand_cnt), 1);
      check("bp_back_idle", 32'(dbg), 32'(S_IDLE));

      // flush mid-BUSY
      issue(1000, 3, 0, 12'h001, 1, 2'b10, 0, 0, 2'd2, 5'd8);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("flush_busy_pre", 32'(dbg), 32'(S_BUSY));
      @(posedge clk); #1 flush = 1;
      @(posedge clk); #1 flush = 0;
      @(negedge clk);
      check("flush_busy_state", 32'(dbg), 32'(S_IDLE));
      check("flush_busy_fwd", 32'(bus.es_fwd_valid), 0);
      hand_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         hand_cnt += int'(bus.es_to_ms_valid);
      end
      check("flush_busy_no_valid", 32'(hand_cnt), 0);

      // flush coinciding with DONE handoff
      issue(77, 5, 0, 12'h001, 1, 2'b00, 0, 0, 2'd2, 5'd9);
      bus.ms_allowin = 0;
      wait_state(S_DONE, "flush_done_reach");
      @(posedge clk); #1 bus.ms_allowin = 1; flush = 1;
      #1 check("flush_done_valid", 32'(bus.es_to_ms_valid), 0);
      @(posedge clk); #1 flush = 0;
      @(negedge clk);
      check("flush_done_state", 32'(dbg), 32'(S_IDLE));
      check("flush_done_empty", 32'(bus.es_fwd_valid), 0);

      // reset mid-divide
      issue(500, 9, 0, 12'h001, 1, 2'b00, 0, 0, 2'd2, 5'd10);
      repeat (5) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      check("rst_mid_state", 32'(dbg), 32'(S_IDLE));
      check("rst_mid_valid", 32'(bus.es_to_ms_valid), 0);
      check("rst_mid_allowin", 32'(bus.es_allowin), 1);

      // back to normal after reset
      do_alu("post_rst_sub", 1, 32'd10, 32'd12);

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised execute stage for the in-order pipeline. It sits between the decode stage and the memory stage and keeps the existing valid/allowin handshake. Compared with the single-cycle stage, it adds:
- an iterative multi-cycle divider with pipeline stall;
- sub-word store byte-lane generation and alignment checking;
- a forwarding port back to decode;
- a flush input.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 and 64 are legal.
- NB, XLEN/8, number of byte lanes.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  kills the instruction held in ES and aborts the divider.
- ds_to_es_valid  in  1  decode presents an instruction.
- es_allowin  out  1  ES accepts an instruction this cycle.
- in_pc, in_src1, in_src2, in_st_data  in  XLEN each  PC, selected ALU operands, store data.
- in_alu_op  in  12  one-hot ALU op, passed to the existing alu.
- in_div_en  in  1  the instruction is a divide.
- in_div_op  in  2  divide kind: 00 div signed, 01 mod signed, 10 div unsigned, 11 mod unsigned.
- in_load, in_store  in  1 each  memory op kind.
- in_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword only when XLEN=64).
- in_gr_we  in  1  register writeback enable.
- in_dest  in  5  destination register.
- ms_allowin  in  1  memory stage can accept.
- es_to_ms_valid  out  1  valid towards MS.
- es_pc, es_result  out  XLEN each  PC and result (ALU, divider, or address).
- es_load, es_gr_we, es_ale  out  1 each  load flag, writeback enable, address-misaligned flag.
- es_dest  out  5  destination register.
- es_mem_size  out  2  size of the memory op.
- es_addr_lo  out  $clog2(NB)  low address bits, used by MS to align loads.
- data_sram_en  out  1  data SRAM request.
- data_sram_we  out  NB  byte write enables.
- data_sram_addr, data_sram_wdata  out  XLEN each  request address and write data.
- es_fwd_valid  out  1  ES holds a valid instruction with gr_we=1.
- es_fwd_block  out  1  ES result is not yet usable (load, or divide not in DONE).
- es_fwd_dest  out  5  forwarded destination register.
- es_fwd_data  out  XLEN  forwarded value.

## Operation
Pipeline handshake:
- es_allowin = !es_valid || (es_ready_go && ms_allowin).
- The input fields are latched when es_allowin=1.
- es_valid <= ds_to_es_valid when es_allowin=1. flush forces es_valid <= 0 and overrides a simultaneous latch.
- es_to_ms_valid = es_valid && es_ready_go && !flush.
- es_ready_go = 1 for non-divide instructions; for a divide, es_ready_go = (state==DONE).

Divider FSM (IDLE, BUSY, DONE):
- IDLE: if es_valid && div_en && !flush, load |dividend| and |divisor| (signed ops take absolute values), count <= XLEN, record result signs, go to BUSY.
- BUSY: one restoring step per cycle, producing one quotient bit MSB first; count decrements. At count==1 the step completes and the FSM goes to DONE.
- DONE: apply the sign fix (quotient is negative when operand signs differ; remainder takes the dividend's sign), drive es_result. Go to IDLE when es_to_ms_valid && ms_allowin.
- flush in any state: go to IDLE next cycle.
- The 32-bit divide ops use the low 32 bits of the operands and sign-extend the result when XLEN=64.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed MIN/-1: quotient = MIN, remainder = 0.

Memory ops:
- Address = ALU result (ADD).
- Aligned when addr[size-1:0]==0; otherwise es_ale=1.
- A misaligned op still flows to MS with es_ale=1, but issues no SRAM request.
- data_sram_en = es_valid && (load||store) && !es_ale && ms_allowin && !flush. The request is issued exactly once, in the handoff cycle.
- data_sram_we = store ? ((1<<(1<<size))-1) << addr_lo : 0.
- data_sram_wdata = the low (8<<size) bits of st_data replicated across XLEN.

Forwarding:
- es_fwd_data = es_result.

## Timing
Reset:
- es_valid=0, FSM=IDLE.
- All outputs are 0: es_to_ms_valid, data_sram_en, data_sram_we, es_fwd_valid, es_fwd_block, es_ale.
- es_allowin=1.

Latency (ms_allowin held high):
- ALU, load, or store: 1 cycle in ES; the SRAM request occurs in that cycle.
- Divide: entry cycle (IDLE) + XLEN BUSY cycles + 1 DONE cycle = XLEN+2 cycles.
- es_allowin is 0 from the entry cycle until the DONE handoff cycle.

Boundary conditions:
- MS back-pressure in DONE: the result is held and the FSM stays in DONE.
- Back-pressure on a memory op: no request is issued until ms_allowin=1.
- flush in the same cycle as the DONE handoff: no valid is passed to MS, and the FSM returns to IDLE.
- reset mid-divide: the FSM returns to IDLE on the next edge.

## Test plan
- ADD 3+4 with ms_allowin=1 → es_result=7, es_to_ms_valid in the cycle after the latch, es_allowin stays 1.
- div.w −7/2 (XLEN=32) → quotient −3 in DONE, 34 cycles in ES; mod.w gives −1; es_fwd_block=1 until DONE.
- div.w 5/0 → 0xFFFFFFFF; mod.wu 5/0 → 5; div.w 0x80000000/−1 → 0x80000000, remainder 0.
- st.b data 0xAB at addr 0x1003 → we=4'b1000, wdata=0xABABABAB; st.h at 0x1001 → es_ale=1, data_sram_en=0.
- Divide in DONE with ms_allowin=0 for 5 cycles → result stable, single handoff; then flush asserted mid-BUSY → FSM returns to IDLE, no es_to_ms_valid.
- Load with ms_allowin low for 3 cycles → data_sram_en pulses exactly once, in the handoff cycle.
